// File: rtl/clock_divider_bank.sv
// Multi-channel programmable clock/tick generator. Each channel counts enabled cycles up to its
// divisor, strobing tick at terminal count and toggling sclk in square mode.
module clock_divider_bank #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 5000000,
  parameter int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  output logic [NUM_CH-1:0] sclk,
  output logic [NUM_CH-1:0] tick
);

  logic [CNT_W-1:0]  count_q [NUM_CH];
  logic [CNT_W-1:0]  count_d [NUM_CH];
  logic [CNT_W-1:0]  div_q   [NUM_CH];
  logic [CNT_W-1:0]  div_d   [NUM_CH];
  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [NUM_CH-1:0] sclk_q, sclk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic              cfg_ready_q, cfg_ready_d;
  logic              xfer;

  assign xfer = cfg_valid && cfg_ready_q;
  // Ready dips for one cycle after every accepted word, otherwise sits high.
  assign cfg_ready_d = !xfer;

  always_comb begin
    count_d = count_q;
    div_d   = div_q;
    mode_d  = mode_q;
    sclk_d  = sclk_q;
    tick_d  = tick_q;
    for (int i = 0; i < NUM_CH; i++) begin
      // A config write to this channel overrides any terminal count on the same edge.
      if (xfer && (cfg_ch == CH_W'(i))) begin
        div_d[i]   = cfg_div;
        mode_d[i]  = cfg_mode;
        count_d[i] = '0;
        sclk_d[i]  = 1'b0;
        tick_d[i]  = 1'b0;
      end else if (en[i]) begin
        if (count_q[i] == div_q[i]) begin
          count_d[i] = '0;
          tick_d[i]  = 1'b1;
          sclk_d[i]  = mode_q[i] ? 1'b0 : ~sclk_q[i];
        end else begin
          count_d[i] = count_q[i] + 1'b1;
          tick_d[i]  = 1'b0;
        end
      end else begin
        tick_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        count_q[i] <= '0;
        div_q[i]   <= CNT_W'(DEFAULT_DIV);
      end
      mode_q      <= '0;
      sclk_q      <= '0;
      tick_q      <= '0;
      cfg_ready_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      div_q       <= div_d;
      mode_q      <= mode_d;
      sclk_q      <= sclk_d;
      tick_q      <= tick_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign sclk      = sclk_q;
  assign tick      = tick_q;
  assign cfg_ready = cfg_ready_q;

endmodule
